// File: rtl/merger_pkg.sv
// Shared definitions for the merger tree: default word width, the terminator
// word appended after each run, and the fill sequencer state encoding.
package merger_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] TERM_WORD = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/leaf_fill_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo N, and reports the grant both one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int cand;
        logic [IDX_W-1:0] candIdx;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        candIdx = '0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                cand = int'(ptr_i) + i;
                if (cand >= N) begin
                    cand = cand - N;
                end
                candIdx = IDX_W'(cand);
                if (!valid_o && req_i[candIdx]) begin
                    valid_o          = 1'b1;
                    idx_o            = candIdx;
                    grant_o[candIdx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/leaf_fill_scheduler.sv
// Streams LEAF_CNT sorted runs from a single-port run memory into the leaf
// FIFOs of the merger tree, appending TERM_CNT zero words after each run.
module leaf_fill_scheduler
    import merger_pkg::*;
#(
    parameter int LEAF_CNT   = 8,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_SEQ    = 128,
    parameter int TERM_CNT   = 4,
    parameter int ADDR_WIDTH = $clog2(LEAF_CNT * LEN_SEQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic [LEAF_CNT-1:0]   i_fifo_full,
    output logic [LEAF_CNT-1:0]   o_fifo_write,
    output logic [DATA_WIDTH-1:0] o_fifo_data
);

    localparam int IDX_W = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1;
    localparam int OFF_W = $clog2(LEN_SEQ);
    localparam int CNT_W = $clog2(LEN_SEQ + TERM_CNT + 1);

    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LEN_SEQ);
    localparam logic [CNT_W-1:0] FIN_C    = CNT_W'(LEN_SEQ + TERM_CNT);
    localparam logic [CNT_W-1:0] FIN_M1   = CNT_W'(LEN_SEQ + TERM_CNT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEAF_CNT - 1);

    fill_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q [LEAF_CNT];
    logic [IDX_W-1:0]    ptr_q;
    logic [LEAF_CNT-1:0] prevGrant_q;
    logic [LEAF_CNT-1:0] fifoWrite_q;
    logic                rdPend_q;

    logic [LEAF_CNT-1:0] finished;
    logic [LEAF_CNT-1:0] eligible;
    logic [LEAF_CNT-1:0] doneAfter;
    logic [LEAF_CNT-1:0] grant;
    logic [IDX_W-1:0]    grantIdx;
    logic                grantValid;
    logic                grantEn;
    logic                grantRead;
    logic                startAccept;
    logic [CNT_W-1:0]    grantCnt;

    // A leaf granted last cycle is masked: its write has not landed, so its
    // full flag cannot yet be trusted.
    always_comb begin
        finished  = '0;
        eligible  = '0;
        doneAfter = '0;
        for (int k = 0; k < LEAF_CNT; k++) begin
            finished[k]  = (cnt_q[k] == FIN_C);
            eligible[k]  = !finished[k] && !i_fifo_full[k] && !prevGrant_q[k];
            doneAfter[k] = finished[k] || (grant[k] && (cnt_q[k] == FIN_M1));
        end
    end

    assign grantEn = (state_q == FILL);

    rr_arbiter #(
        .N     (LEAF_CNT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .en_i    (grantEn),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .valid_o (grantValid)
    );

    assign grantCnt  = cnt_q[grantIdx];
    assign grantRead = grantValid && (grantCnt < LEN_C);

    always_comb begin
        state_d     = state_q;
        startAccept = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = FILL;
                    startAccept = 1'b1;
                end
            end
            FILL: begin
                if (&doneAfter) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            prevGrant_q <= '0;
            fifoWrite_q <= '0;
            rdPend_q    <= 1'b0;
            for (int k = 0; k < LEAF_CNT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            prevGrant_q <= grant;
            fifoWrite_q <= grant;
            rdPend_q    <= grantRead;
            if (startAccept) begin
                ptr_q <= '0;
                for (int k = 0; k < LEAF_CNT; k++) begin
                    cnt_q[k] <= '0;
                end
            end else if (grantValid) begin
                cnt_q[grantIdx] <= grantCnt + 1'b1;
                ptr_q           <= (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
            end
        end
    end

    // Leaf base address is the leaf index concatenated above the word offset.
    assign o_mem_rd     = grantRead;
    assign o_mem_addr   = grantRead ? ADDR_WIDTH'({grantIdx, grantCnt[OFF_W-1:0]}) : '0;
    assign o_fifo_write = fifoWrite_q;
    assign o_fifo_data  = rdPend_q ? i_mem_data : DATA_WIDTH'(TERM_WORD);
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);

endmodule
